// File: rtl/traffic_signal_monitor.sv
// Receive-side checker for the active-low traffic signal LED bus: decodes the
// held pattern, measures run lengths and checks phase order and timing.
module traffic_signal_monitor #(
   parameter int unsigned RED_CYCLES   = 240_000_000,
   parameter int unsigned GREEN_CYCLES = 120_000_000,
   parameter int unsigned BLUE_CYCLES  = 48_000_000,
   parameter int unsigned OFF_CYCLES   = 1,
   parameter int unsigned TOL_CYCLES   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  led_in,
   input  logic        err_clr,
   output logic [1:0]  phase,
   output logic        phase_valid,
   output logic [31:0] last_dur,
   output logic [1:0]  last_phase,
   output logic        dur_valid,
   output logic        seq_err,
   output logic        dur_err,
   output logic        pat_err,
   output logic [15:0] cycle_count
);

   // state     | meaning
   // WAIT_SYNC | not locked; waiting for a 111 -> 110 edge
   // RED       | locked, RED (110) held
   // GREEN     | locked, GREEN (011) held
   // BLUE      | locked, BLUE (101) held
   // OFF       | locked, all-off (111) gap held
   typedef enum logic [2:0] {WAIT_SYNC, RED, GREEN, BLUE, OFF} state_t;

   localparam logic [2:0] PAT_RED   = 3'b110;
   localparam logic [2:0] PAT_GREEN = 3'b011;
   localparam logic [2:0] PAT_BLUE  = 3'b101;
   localparam logic [2:0] PAT_OFF   = 3'b111;
   localparam logic [32:0] TOL33    = 33'(TOL_CYCLES);

   function automatic logic [1:0] decode(input logic [2:0] p);
      case (p)
         PAT_RED:   decode = 2'd0;
         PAT_GREEN: decode = 2'd1;
         PAT_BLUE:  decode = 2'd2;
         default:   decode = 2'd3;
      endcase
   endfunction

   function automatic logic legal(input logic [2:0] p);
      legal = (p == PAT_RED) || (p == PAT_GREEN) || (p == PAT_BLUE) || (p == PAT_OFF);
   endfunction

   state_t      state, state_nx, succ_state;
   logic [2:0]  cur_pat, succ_pat;
   logic [31:0] run, run_inc;
   logic [32:0] exp33;
   logic        long_done;
   logic        edge_det, short_hit, long_hit;
   logic        set_seq, set_dur, set_pat, cyc_inc;

   assign edge_det  = (led_in != cur_pat);
   assign run_inc   = (run == 32'hFFFF_FFFF) ? run : run + 32'd1;
   // 33-bit arithmetic so neither E+TOL nor E-TOL can wrap
   assign short_hit = (({1'b0, run} + TOL33) < exp33);
   assign long_hit  = ({1'b0, run_inc} > (exp33 + TOL33));

   always_comb begin
      exp33      = '0;
      succ_pat   = PAT_RED;
      succ_state = WAIT_SYNC;
      case (state)
         RED:     begin exp33 = 33'(RED_CYCLES);   succ_pat = PAT_GREEN; succ_state = GREEN; end
         GREEN:   begin exp33 = 33'(GREEN_CYCLES); succ_pat = PAT_BLUE;  succ_state = BLUE;  end
         BLUE:    begin exp33 = 33'(BLUE_CYCLES);  succ_pat = PAT_OFF;   succ_state = OFF;   end
         OFF:     begin exp33 = 33'(OFF_CYCLES);   succ_pat = PAT_RED;   succ_state = RED;   end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WAIT_SYNC;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      set_seq  = 1'b0;
      set_dur  = 1'b0;
      set_pat  = 1'b0;
      cyc_inc  = 1'b0;
      if (edge_det) begin
         if (!legal(led_in)) begin
            set_pat  = 1'b1;
            state_nx = WAIT_SYNC;
         end else if (state == WAIT_SYNC) begin
            if (cur_pat == PAT_OFF && led_in == PAT_RED) state_nx = RED;
         end else if (led_in == succ_pat) begin
            state_nx = succ_state;
            cyc_inc  = (state == OFF);
         end else begin
            set_seq  = 1'b1;
            state_nx = WAIT_SYNC;
         end
         if (state != WAIT_SYNC && short_hit) set_dur = 1'b1;
      end else if (state != WAIT_SYNC && !long_done && long_hit) begin
         set_dur = 1'b1;
      end
   end

   always_comb begin
      phase       = decode(cur_pat);
      phase_valid = (state != WAIT_SYNC);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_pat     <= PAT_OFF;
         run         <= '0;
         long_done   <= 1'b0;
         last_dur    <= '0;
         last_phase  <= '0;
         dur_valid   <= 1'b0;
         seq_err     <= 1'b0;
         dur_err     <= 1'b0;
         pat_err     <= 1'b0;
         cycle_count <= '0;
      end else begin
         if (edge_det) begin
            last_dur   <= run;
            last_phase <= decode(cur_pat);
            dur_valid  <= 1'b1;
            cur_pat    <= led_in;
            run        <= 32'd1;
            long_done  <= 1'b0;
         end else begin
            dur_valid <= 1'b0;
            run       <= run_inc;
            if (long_hit) long_done <= 1'b1;
         end
         // a new error in the same cycle as err_clr must win
         seq_err     <= (seq_err & ~err_clr) | set_seq;
         dur_err     <= (dur_err & ~err_clr) | set_dur;
         pat_err     <= (pat_err & ~err_clr) | set_pat;
         cycle_count <= cycle_count + 16'(cyc_inc);
      end
   end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: directed scenarios plus random segments,
// checked every cycle against a run-length/phase-order reference model.
module tb_traffic_signal_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  led_in;
   logic        err_clr;
   logic [1:0]  phase;
   logic        phase_valid;
   logic [31:0] last_dur;
   logic [1:0]  last_phase;
   logic        dur_valid;
   logic        seq_err, dur_err, pat_err;
   logic [15:0] cycle_count;

   int checks = 0;
   int errors = 0;

   traffic_signal_monitor #(
      .RED_CYCLES(10), .GREEN_CYCLES(5), .BLUE_CYCLES(2), .OFF_CYCLES(1), .TOL_CYCLES(0)
   ) dut (
      .clk(clk), .rst(rst), .led_in(led_in), .err_clr(err_clr),
      .phase(phase), .phase_valid(phase_valid), .last_dur(last_dur),
      .last_phase(last_phase), .dur_valid(dur_valid), .seq_err(seq_err),
      .dur_err(dur_err), .pat_err(pat_err), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   localparam int TOL = 0;
   int E [4] = '{10, 5, 2, 1};

   // reference model: held pattern, its run length, lock flag
   logic [2:0] m_pat;
   longint     m_run;
   bit         m_locked, m_fired, m_dv, m_seq, m_dur, m_patf;
   longint     m_ld;
   int         m_lp, m_cc;

   function automatic int ph(input logic [2:0] p);
      if (p == 3'b110) return 0;
      if (p == 3'b011) return 1;
      if (p == 3'b101) return 2;
      return 3;
   endfunction

   function automatic bit is_legal(input logic [2:0] p);
      return p == 3'b110 || p == 3'b011 || p == 3'b101 || p == 3'b111;
   endfunction

   function automatic logic [2:0] pat_of(input int p);
      logic [2:0] t [4] = '{3'b110, 3'b011, 3'b101, 3'b111};
      return t[p % 4];
   endfunction

   task automatic model_reset();
      m_pat = 3'b111; m_run = 0; m_locked = 0; m_fired = 0; m_dv = 0;
      m_seq = 0; m_dur = 0; m_patf = 0; m_ld = 0; m_lp = 0; m_cc = 0;
   endtask

   task automatic model_step(input logic [2:0] s, input bit c);
      bit ns = 0, nd = 0, np = 0;
      if (s != m_pat) begin
         m_dv = 1; m_ld = m_run; m_lp = ph(m_pat);
         if (m_locked && (m_run + TOL < E[ph(m_pat)])) nd = 1;
         if (!is_legal(s)) begin
            np = 1; m_locked = 0;
         end else if (!m_locked) begin
            if (m_pat == 3'b111 && s == 3'b110) m_locked = 1;
         end else if (ph(s) == (ph(m_pat) + 1) % 4) begin
            if (ph(s) == 0) m_cc = (m_cc + 1) % 65536;
         end else begin
            ns = 1; m_locked = 0;
         end
         m_pat = s; m_run = 1; m_fired = 0;
      end else begin
         m_dv = 0;
         if (m_run < 64'hFFFF_FFFF) m_run++;
         if (m_locked && !m_fired && m_run > E[ph(m_pat)] + TOL) begin
            nd = 1; m_fired = 1;
         end
      end
      m_seq  = (m_seq  && !c) || ns;
      m_dur  = (m_dur  && !c) || nd;
      m_patf = (m_patf && !c) || np;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("phase",       32'(phase),       32'(ph(m_pat)));
      chk("phase_valid", 32'(phase_valid), 32'(m_locked));
      chk("dur_valid",   32'(dur_valid),   32'(m_dv));
      chk("last_dur",    last_dur,         32'(m_ld));
      chk("last_phase",  32'(last_phase),  32'(m_lp));
      chk("seq_err",     32'(seq_err),     32'(m_seq));
      chk("dur_err",     32'(dur_err),     32'(m_dur));
      chk("pat_err",     32'(pat_err),     32'(m_patf));
      chk("cycle_count", 32'(cycle_count), 32'(m_cc));
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_phase"}, 32'(phase), 32'd3);
      chk({tag, "_pv"},    32'(phase_valid), 32'd0);
      chk({tag, "_dv"},    32'(dur_valid), 32'd0);
      chk({tag, "_ld"},    last_dur, 32'd0);
      chk({tag, "_lp"},    32'(last_phase), 32'd0);
      chk({tag, "_errs"},  32'({seq_err, dur_err, pat_err}), 32'd0);
      chk({tag, "_cc"},    32'(cycle_count), 32'd0);
   endtask

   task automatic step(input logic [2:0] s, input bit c);
      led_in = s; err_clr = c;
      @(posedge clk);
      model_step(s, c);
      #1;
      check_all();
   endtask

   task automatic hold(input logic [2:0] s, input int n);
      for (int k = 0; k < n; k++) step(s, 1'b0);
   endtask

   task automatic full_cycle();
      hold(3'b110, 10); hold(3'b011, 5); hold(3'b101, 2); hold(3'b111, 1);
   endtask

   initial begin
      rst = 1'b1; led_in = 3'b111; err_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;

      // nominal: three full cycles
      for (int i = 0; i < 3; i++) full_cycle();
      step(3'b110, 0);
      chk("nominal_cc", 32'(cycle_count), 32'd3);
      chk("nominal_errs", 32'({seq_err, dur_err, pat_err}), 32'd0);

      // order: RED then BLUE, relock on 111 -> 110
      hold(3'b110, 9); hold(3'b101, 2);
      chk("order_seq", 32'(seq_err), 32'd1);
      chk("order_pv", 32'(phase_valid), 32'd0);
      hold(3'b110, 2); hold(3'b111, 1); step(3'b110, 0);
      chk("order_relock", 32'(phase_valid), 32'd1);
      step(3'b110, 1);

      // timing: GREEN long, BLUE short
      hold(3'b110, 8); hold(3'b011, 7); hold(3'b101, 1); hold(3'b111, 1);
      chk("timing_dur", 32'(dur_err), 32'd1);
      chk("timing_noseq", 32'(seq_err), 32'd0);

      // illegal pattern mid-RED, then clear
      hold(3'b110, 4); step(3'b000, 0);
      chk("illegal_pat", 32'(pat_err), 32'd1);
      step(3'b000, 1);
      chk("illegal_clr", 32'({seq_err, dur_err, pat_err}), 32'd0);

      // err_clr coincident with out-of-order edge
      hold(3'b111, 1); hold(3'b110, 10); step(3'b101, 1);
      chk("simul_seq", 32'(seq_err), 32'd1);
      step(3'b101, 1);

      // async reset mid-BLUE
      hold(3'b111, 1); hold(3'b110, 10); hold(3'b011, 5); hold(3'b101, 1);
      #2 rst = 1'b1;
      #1 check_reset_values("async");
      @(posedge clk);
      #1 check_reset_values("async_hold");
      rst = 1'b0;
      model_reset();
      step(3'b101, 0); step(3'b111, 0); step(3'b110, 0);
      chk("async_relock", 32'(phase_valid), 32'd1);

      // random segments, mostly in order with jittered lengths
      for (int i = 0; i < 60; i++) begin
         int kind = $urandom_range(0, 9);
         logic [2:0] p;
         int len;
         if (kind == 0) begin
            logic [2:0] ill [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
            p = ill[$urandom_range(0, 3)];
            len = $urandom_range(1, 2);
         end else if (kind == 1) begin
            p = pat_of($urandom_range(0, 3));
            len = $urandom_range(1, 4);
         end else begin
            p = is_legal(m_pat) ? pat_of(ph(m_pat) + 1) : 3'b111;
            len = E[ph(p)] + $urandom_range(0, 2) - 1;
            if (len < 1) len = 1;
         end
         for (int k = 0; k < len; k++) step(p, ($urandom_range(0, 7) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
